// File: rtl/rdid_spi_master.sv
// SPI mode-0 master that issues one RDID (0x9F) command and captures the 24-bit JEDEC ID.
// Optional macro RDID_MISO_SYNC_EN: double-flop miso and sample it on sclk falling edges.
module rdid_spi_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        miso,
    output logic        cs_n,
    output logic        sclk,
    output logic        mosi,
    output logic [23:0] id_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        READ,
        HOLD
    } state_t;

    localparam logic [7:0] RDID_CMD = 8'h9F;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [6:0] H_READ   = 7'd16;
    localparam logic [6:0] H_HOLD   = 7'd64;

    state_t      state_q, state_d;
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [23:0] id_q, id_d;
    logic [7:0]  div_q, div_d;
    logic [6:0]  half_q, half_d;
    logic [7:0]  sr_q, sr_d;
    logic [23:0] cap_q, cap_d;

    logic        tick;
    logic [6:0]  hnext;
    logic        miso_smp;

`ifdef RDID_MISO_SYNC_EN
    // Synchronized data lags by two clocks, so it is taken at the falling edge ending each bit.
    localparam logic SAMPLE_ON_RISE = 1'b0;
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], miso};
        end
    end

    assign miso_smp = sync_q[1];
`else
    localparam logic SAMPLE_ON_RISE = 1'b1;
    assign miso_smp = miso;
`endif

    // Events (sclk edges) happen every CLK_DIV clocks; odd event numbers are rises.
    assign tick  = (div_q == DIV_LAST);
    assign hnext = half_q + 7'd1;

    always_comb begin
        state_d = state_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        id_d    = id_q;
        div_d   = div_q;
        half_d  = half_q;
        sr_d    = sr_q;
        cap_d   = cap_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CMD;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    mosi_d  = RDID_CMD[7];
                    sr_d    = {RDID_CMD[6:0], 1'b0};
                    div_d   = 8'd0;
                    half_d  = 7'd0;
                end
            end
            CMD, READ: begin
                div_d = tick ? 8'd0 : div_q + 8'd1;
                if (tick) begin
                    half_d = hnext;
                    sclk_d = hnext[0];
                    if (state_q == READ && hnext[0] == SAMPLE_ON_RISE) begin
                        cap_d = {cap_q[22:0], miso_smp};
                    end
                    if (!hnext[0]) begin
                        // Shift register drains to zero, so mosi idles low after the command byte.
                        mosi_d = sr_q[7];
                        sr_d   = {sr_q[6:0], 1'b0};
                        if (hnext == H_READ) begin
                            state_d = READ;
                        end else if (hnext == H_HOLD) begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                div_d = tick ? 8'd0 : div_q + 8'd1;
                if (tick) begin
                    half_d  = hnext;
                    state_d = IDLE;
                    cs_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    id_d    = cap_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            id_q    <= 24'h000000;
        end else begin
            state_q <= state_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            id_q    <= id_d;
        end
    end

    // Datapath counters and shifters are always reloaded at transaction start.
    always_ff @(posedge clk) begin
        div_q  <= div_d;
        half_q <= half_d;
        sr_q   <= sr_d;
        cap_q  <= cap_d;
    end

    assign cs_n   = cs_n_q;
    assign sclk   = sclk_q;
    assign mosi   = mosi_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign id_out = id_q;

endmodule

// File: tb/tb_rdid_spi_master.sv
// Bench for rdid_spi_master: CLK_DIV=4 and CLK_DIV=2 instances, flash model and timing-formula reference.
module tb_rdid_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  start_v, miso_v, cs_n_v, sclk_v, mosi_v, busy_v, done_v;
    logic [23:0] id_v     [2];
    logic [23:0] flash_id [2];

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    rdid_spi_master #(.CLK_DIV(4)) u_div4 (
        .clk(clk), .reset(reset), .start(start_v[0]), .miso(miso_v[0]),
        .cs_n(cs_n_v[0]), .sclk(sclk_v[0]), .mosi(mosi_v[0]),
        .id_out(id_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    rdid_spi_master #(.CLK_DIV(2)) u_div2 (
        .clk(clk), .reset(reset), .start(start_v[1]), .miso(miso_v[1]),
        .cs_n(cs_n_v[1]), .sclk(sclk_v[1]), .mosi(mosi_v[1]),
        .id_out(id_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    function automatic int div_of(input int g);
        return (g == 0) ? 4 : 2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: a transaction is just "cycles since T0"; outputs follow from that count.
    bit          m_active [2] = '{0, 0};
    int          m_e      [2] = '{0, 0};
    logic [23:0] m_id     [2] = '{24'h0, 24'h0};
    logic [23:0] m_cur    [2] = '{24'h0, 24'h0};
    bit          m_done   [2] = '{0, 0};

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (reset) begin
                m_active[g] <= 1'b0;
                m_done[g]   <= 1'b0;
                m_id[g]     <= 24'h0;
            end else begin
                m_done[g] <= 1'b0;
                if (m_active[g]) begin
                    if (m_e[g] + 1 == 65 * div_of(g)) begin
                        m_active[g] <= 1'b0;
                        m_done[g]   <= 1'b1;
                        m_id[g]     <= m_cur[g];
                    end else begin
                        m_e[g] <= m_e[g] + 1;
                    end
                end else if (start_v[g]) begin
                    m_active[g] <= 1'b1;
                    m_e[g]      <= 0;
                    m_cur[g]    <= flash_id[g];
                end
            end
        end
    end

    // {cs_n, sclk, mosi, busy, done, id_out}
    function automatic logic [28:0] exp_word(input int g);
        logic [7:0] cmd = 8'h9F;
        int h;
        int k;
        logic s;
        logic m;
        if (m_active[g]) begin
            h = m_e[g] / div_of(g);
            s = (h % 2 == 1) && (h < 64);
            k = h / 2;
            m = (k < 8) ? cmd[7-k] : 1'b0;
            return {1'b0, s, m, 1'b1, 1'b0, m_id[g]};
        end
        return {1'b1, 1'b0, 1'b0, 1'b0, m_done[g], m_id[g]};
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int g = 0; g < 2; g++) begin
                    check($sformatf("cycle_g%0d", g),
                          {3'b000, cs_n_v[g], sclk_v[g], mosi_v[g], busy_v[g], done_v[g], id_v[g]},
                          {3'b000, exp_word(g)});
                end
            end
        end
    end

    // Flash model: after the falling edge ending bit k-1 it drives bit k; random filler elsewhere.
    int   fl_cnt  [2] = '{0, 0};
    logic fl_prev [2] = '{1'b0, 1'b0};

    initial begin
        miso_v = 2'b00;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (cs_n_v[g] !== 1'b0) begin
                    fl_cnt[g] = 0;
                end else if (fl_prev[g] === 1'b1 && sclk_v[g] === 1'b0) begin
                    fl_cnt[g]++;
                end
                fl_prev[g] = sclk_v[g];
                if (fl_cnt[g] >= 8 && fl_cnt[g] <= 31) begin
                    miso_v[g] = flash_id[g][31-fl_cnt[g]];
                end else begin
                    miso_v[g] = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    task automatic txn(input int g, input logic [23:0] id, input bit glitch, input bit linger,
                       output int lat, output int dones, output int rises, output logic [7:0] mpat);
        int   d = div_of(g);
        logic prev = 1'b0;
        lat   = -1;
        dones = 0;
        rises = 0;
        mpat  = 8'h00;
        flash_id[g] = id;
        start_v[g]  = 1'b1;
        for (int n = 1; n <= 70 * d + 20 + (linger ? 130 * d : 0); n++) begin
            @(negedge clk);
            start_v[g] = glitch && (n == 50 || n == 100 || n == 65 * d);
            if (sclk_v[g] === 1'b1 && prev !== 1'b1) begin
                if (rises < 8) mpat = {mpat[6:0], mosi_v[g]};
                rises++;
            end
            prev = sclk_v[g];
            if (done_v[g] === 1'b1) begin
                dones++;
                if (lat < 0) lat = n - 1;
                if (!linger) break;
            end
        end
        start_v[g] = 1'b0;
    endtask

    task automatic abort_txn(input int g, input logic [23:0] id, input int at);
        int dones = 0;
        flash_id[g] = id;
        start_v[g]  = 1'b1;
        for (int n = 1; n <= at; n++) begin
            @(negedge clk);
            start_v[g] = 1'b0;
            if (n == at) reset = 1'b1;
        end
        @(negedge clk);
        check("abort_cs_n", {31'b0, cs_n_v[g]}, 32'd1);
        check("abort_sclk", {31'b0, sclk_v[g]}, 32'd0);
        check("abort_busy", {31'b0, busy_v[g]}, 32'd0);
        check("abort_id", {8'h0, id_v[g]}, 32'h0);
        reset = 1'b0;
        for (int n = 0; n < 70 * div_of(g); n++) begin
            @(negedge clk);
            if (done_v[g] === 1'b1) dones++;
        end
        check("abort_no_done", dones, 0);
    endtask

    int          lat, dones, rises;
    logic [7:0]  mpat;
    logic [23:0] rid;
    int          rg;

    initial begin
        reset       = 1'b1;
        start_v     = 2'b00;
        flash_id[0] = 24'h0;
        flash_id[1] = 24'h0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_cs_n", {30'b0, cs_n_v}, 32'd3);
        check("reset_sclk", {30'b0, sclk_v}, 32'd0);
        check("reset_mosi", {30'b0, mosi_v}, 32'd0);
        check("reset_busy", {30'b0, busy_v}, 32'd0);
        check("reset_done", {30'b0, done_v}, 32'd0);
        check("reset_id", {8'h0, id_v[0]}, 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Basic transaction, with the returned ID, latency and MOSI byte pinned by hand.
        txn(0, 24'h20BA18, 1'b0, 1'b1, lat, dones, rises, mpat);
        check("basic_latency", lat, 260);
        check("basic_rises", rises, 32);
        check("basic_mosi", {24'h0, mpat}, 32'h9F);
        check("basic_dones", dones, 1);
        check("basic_id", {8'h0, id_v[0]}, 32'h20BA18);

        // Back-to-back: the second start lands the cycle after done.
        txn(0, 24'hEF4016, 1'b0, 1'b0, lat, dones, rises, mpat);
        check("b2b_first_id", {8'h0, id_v[0]}, 32'hEF4016);
        txn(0, 24'hC22017, 1'b0, 1'b0, lat, dones, rises, mpat);
        check("b2b_second_latency", lat, 260);
        check("b2b_second_id", {8'h0, id_v[0]}, 32'hC22017);

        // Starts at T0+50, T0+100 and on the done edge are all ignored.
        txn(0, 24'h5A3C96, 1'b1, 1'b1, lat, dones, rises, mpat);
        check("busy_latency", lat, 260);
        check("busy_dones", dones, 1);

        // Reset in the middle of the READ phase, then a clean transaction.
        abort_txn(0, 24'h123456, 120);
        txn(0, 24'h20BA18, 1'b0, 1'b0, lat, dones, rises, mpat);
        check("post_abort_id", {8'h0, id_v[0]}, 32'h20BA18);

        // Fastest divider, all-ones then all-zeros.
        txn(1, 24'hFFFFFF, 1'b0, 1'b0, lat, dones, rises, mpat);
        check("div2_latency", lat, 130);
        check("div2_rises", rises, 32);
        check("div2_id_ones", {8'h0, id_v[1]}, 32'hFFFFFF);
        txn(1, 24'h000000, 1'b0, 1'b0, lat, dones, rises, mpat);
        check("div2_id_zeros", {8'h0, id_v[1]}, 32'h000000);

        // Randomized transactions on both dividers, with occasional aborts.
        for (int i = 0; i < 12; i++) begin
            rg  = int'($urandom_range(0, 1));
            rid = 24'($urandom);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            if (i % 5 == 4) begin
                abort_txn(rg, rid, int'($urandom_range(1, 65 * div_of(rg) - 1)));
            end else begin
                txn(rg, rid, 1'($urandom_range(0, 1)), 1'b0, lat, dones, rises, mpat);
                check($sformatf("rand_latency_%0d", i), lat, 65 * div_of(rg));
                check($sformatf("rand_id_%0d", i), {8'h0, id_v[rg]}, {8'h0, rid});
            end
        end

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
